board_row_arbiter: RTL and testbench
====================================

Name: board_row_arbiter

Overview:
- Owns the single-port board cell RAM: 20 rows x 10 cells, 16-bit cells (12-bit RGB in bits [11:0]).
- Shares that RAM between two requesters:
  - the display path, which fetches one full board row into a row buffer at each block-row boundary;
  - the game logic, which does single-cell reads and writes.
- The display has absolute priority because it has a scan-line deadline. The game port uses a req/gnt handshake.
- Sits between the game-state logic and the colour mapper. It drives the Row[10] buffer the colour mapper indexes.

Parameters:
- BOARD_W, 10, cells per row
- BOARD_H, 20, rows per board
- CELL_W, 16, bits per cell
- ADDR_W, 8, RAM address width; must satisfy 2^ADDR_W >= BOARD_W*BOARD_H

Ports:
- Clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- disp_req  in  1  single-cycle pulse: fetch row disp_row
- disp_row  in  5  row index to fetch, 0..BOARD_H-1
- disp_busy  out  1  display fetch in progress
- disp_done  out  1  one-cycle pulse: row_out updated
- row_out  out  BOARD_W*CELL_W  row buffer; cell c occupies bits [c*CELL_W +: CELL_W]
- game_req  in  1  game access request; held until granted
- game_we  in  1  1 = write, 0 = read; sampled with the grant
- game_row  in  5  cell row
- game_col  in  4  cell column
- game_wdata  in  CELL_W  write data
- game_gnt  out  1  one-cycle pulse: request accepted
- game_rvalid  out  1  one-cycle pulse: game_rdata valid (reads only)
- game_rdata  out  CELL_W  read data; held until the next read
- mem_addr  out  ADDR_W  RAM address = row*BOARD_W + col
- mem_we  out  1  RAM write enable
- mem_wdata  out  CELL_W  RAM write data
- mem_rdata  in  CELL_W  RAM read data, 1-cycle registered latency

Behaviour:
- Reset (reset==0 at a Clk edge) forces:
  - state IDLE;
  - row_out, game_rdata, mem_addr, mem_wdata all 0;
  - disp_busy, disp_done, game_gnt, game_rvalid, mem_we all 0;
  - any pending disp_req latch cleared.
- Reset mid-fetch abandons the fetch. row_out stays 0 until the next completed fetch.
- disp_req is latched into a pending flag together with disp_row.
  - A disp_req arriving while busy overwrites the pending row. Only the newest row is fetched.
  - disp_row >= BOARD_H is ignored: no fetch and no disp_done.
- FSM states:
  - IDLE
    - pending display request -> DFETCH: col counter = 0, disp_busy = 1.
    - else game_req -> GACC: drive mem_addr/mem_we/mem_wdata from the game inputs, game_gnt = 1 in this cycle.
    - Display wins when both are present.
  - DFETCH
    - Issues reads at addr row*BOARD_W + col for col 0..BOARD_W-1, one per cycle.
    - Data for col k is captured in cycle k+1 into a shadow buffer.
    - After the last capture, the shadow buffer is copied to row_out in one cycle and disp_done pulses in that same cycle.
    - Total: disp_req to disp_done = BOARD_W+2 cycles (12 by default) from IDLE.
    - Then return to IDLE, disp_busy = 0.
    - row_out changes only on the disp_done cycle. There are no partial updates.
  - GACC
    - Write: mem_we = 1 for exactly the grant cycle, then IDLE next cycle. The RAM is updated one cycle after game_gnt.
    - Read: one wait cycle, then game_rdata captured and game_rvalid pulses 2 cycles after game_gnt, then IDLE.
    - A display request arriving during GACC waits at most 2 cycles.
- Game requester starvation bound: at most one display fetch (BOARD_W+2 cycles) plus 2 cycles.
- mem_we is 0 in every state other than the GACC write cycle.
- Address arithmetic is computed at ADDR_W width with no truncation for legal inputs.
- game_col >= BOARD_W or game_row >= BOARD_H:
  - the request is still granted;
  - writes are suppressed (mem_we = 0);
  - reads return 0 with game_rvalid.

Optional Feature:
- Macro: BOARD_ROW_CLEAR_EN.
- When defined, adds two ports:
  - clear_req in 1, a pulse;
  - clear_row in 5.
- A clear_req is latched and serviced via a new CLR state. CLR writes 0 to the 10 cells of clear_row, one per cycle, then pulses clear_done out 1.
- Priority: display > clear > game. CLR is never preempted once started.
- When undefined, the ports and state are absent and the behaviour is exactly as above.

Decomposition:
- Shared package board_pkg:
  - BOARD_W, BOARD_H, CELL_W;
  - the cell type (logic [CELL_W-1:0]);
  - the state enum {IDLE, DFETCH, GACC, CLR};
  - a cell_addr(row, col) function.
- One natural sub-module, row_shadow_buffer: the col-indexed capture register file with a commit strobe that produces row_out.

Test Plan:
- Preload cell (3,c) = 16'h0F00 + c. Pulse disp_req with row 3 -> mem_addr steps 30..39; disp_done at cycle 12; row_out cell 9 = 16'h0F09.
- game_req write (5,2) = 16'h00F0, then read (5,2) -> game_gnt on the first cycle; read game_rvalid 2 cycles after its grant; game_rdata = 16'h00F0.
- disp_req and game_req asserted in the same cycle -> DFETCH first; game_gnt exactly 12 cycles later; game write lands after the fetch.
- Assert reset (0) during DFETCH at col 5 -> all outputs 0 next cycle; no disp_done; row_out remains 0.
- game_req read at (20,0), then write at (0,10) -> both granted; read returns 0 with rvalid; mem_we stays 0.
- With BOARD_ROW_CLEAR_EN: clear_req row 19 while a fetch is in progress -> CLR starts after disp_done; addresses 190..199 written with 0; clear_done pulses; a following fetch of row 19 gives all cells 0.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board geometry, cell type, arbiter state encoding and the cell address helper.
package board_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int CELL_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int ROW_W   = 5;
    localparam int COL_W   = 4;
    localparam int STEP_W  = $clog2(BOARD_W + 2);

    typedef logic [CELL_W-1:0] cell_t;

    typedef enum logic [1:0] {
        IDLE,
        DFETCH,
        GACC,
        CLR
    } state_t;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(BOARD_W) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/row_shadow_buffer.sv
// Column-indexed capture registers for one board row. A commit publishes the whole
// row to row_out at once, folding in any capture that lands on the same edge.
module row_shadow_buffer
    import board_pkg::*;
(
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      cap_en,
    input  logic [COL_W-1:0]          cap_col,
    input  logic [CELL_W-1:0]         cap_data,
    input  logic                      commit,
    output logic [BOARD_W*CELL_W-1:0] row_out
);

    cell_t shadow      [BOARD_W];
    cell_t shadow_next [BOARD_W];

    // NOTE: shadow_next gets a full default before the conditional write, so no path infers a latch.
    always_comb begin
        shadow_next = shadow;
        if (cap_en) shadow_next[cap_col] = cap_data;
    end

    // NOTE: the shadow array has no reset; every entry is rewritten during a fetch before a commit reads it.
    always_ff @(posedge Clk) begin
        shadow <= shadow_next;
    end

    // NOTE: registers use non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            row_out <= '0;
        end else if (commit) begin
            for (int c = 0; c < BOARD_W; c++) row_out[c*CELL_W +: CELL_W] <= shadow_next[c];
        end
    end

endmodule

// File: rtl/board_row_arbiter.sv
// Arbitrates the single-port board RAM between display row fetches (absolute priority)
// and game cell accesses. Define BOARD_ROW_CLEAR_EN to add the row-clear port and CLR state.
module board_row_arbiter
    import board_pkg::*;
(
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      disp_req,
    input  logic [ROW_W-1:0]          disp_row,
    output logic                      disp_busy,
    output logic                      disp_done,
    output logic [BOARD_W*CELL_W-1:0] row_out,
    input  logic                      game_req,
    input  logic                      game_we,
    input  logic [ROW_W-1:0]          game_row,
    input  logic [COL_W-1:0]          game_col,
    input  logic [CELL_W-1:0]         game_wdata,
    output logic                      game_gnt,
    output logic                      game_rvalid,
    output logic [CELL_W-1:0]         game_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [CELL_W-1:0]         mem_wdata,
`ifdef BOARD_ROW_CLEAR_EN
    input  logic                      clear_req,
    input  logic [ROW_W-1:0]          clear_row,
    output logic                      clear_done,
`endif
    input  logic [CELL_W-1:0]         mem_rdata
);

    state_t             state;
    logic               disp_pend;
    logic [ROW_W-1:0]   disp_pend_row;
    logic [ADDR_W-1:0]  fetch_base;
    logic [STEP_W-1:0]  step;
    logic               g_read, g_legal, g_wait;

    logic               disp_req_ok, disp_want, game_legal;
    logic [ROW_W-1:0]   disp_take_row;
    logic               cap_en, commit, arb_slot;
    logic [COL_W-1:0]   cap_col;

    assign disp_req_ok   = disp_req && (disp_row < ROW_W'(BOARD_H));
    assign disp_want     = disp_req_ok || disp_pend;
    assign disp_take_row = disp_req_ok ? disp_row : disp_pend_row;
    assign game_legal    = (game_row < ROW_W'(BOARD_H)) && (game_col < COL_W'(BOARD_W));

    // Read data for column k arrives two steps after it was issued.
    assign cap_en   = (state == DFETCH) && (step >= STEP_W'(2));
    assign cap_col  = COL_W'(step - STEP_W'(2));
    assign commit   = (state == DFETCH) && (step == STEP_W'(BOARD_W + 1));
    // The commit cycle doubles as an arbitration slot, so a waiting requester is served alongside disp_done.
    assign arb_slot = (state == IDLE) || commit;

`ifdef BOARD_ROW_CLEAR_EN
    logic             clr_pend, clr_req_ok, clr_want;
    logic [ROW_W-1:0] clr_pend_row, clr_take_row;

    assign clr_req_ok   = clear_req && (clear_row < ROW_W'(BOARD_H));
    assign clr_want     = clr_req_ok || clr_pend;
    assign clr_take_row = clr_req_ok ? clear_row : clr_pend_row;
`endif

    row_shadow_buffer u_shadow (
        .Clk      (Clk),
        .reset    (reset),
        .cap_en   (cap_en),
        .cap_col  (cap_col),
        .cap_data (mem_rdata),
        .commit   (commit),
        .row_out  (row_out)
    );

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state         <= IDLE;
            disp_pend     <= 1'b0;
            disp_pend_row <= '0;
            fetch_base    <= '0;
            step          <= '0;
            g_read        <= 1'b0;
            g_legal       <= 1'b0;
            g_wait        <= 1'b0;
            disp_busy     <= 1'b0;
            disp_done     <= 1'b0;
            game_gnt      <= 1'b0;
            game_rvalid   <= 1'b0;
            game_rdata    <= '0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
`ifdef BOARD_ROW_CLEAR_EN
            clr_pend      <= 1'b0;
            clr_pend_row  <= '0;
            clear_done    <= 1'b0;
`endif
        end else begin
            disp_done   <= 1'b0;
            game_gnt    <= 1'b0;
            game_rvalid <= 1'b0;
            mem_we      <= 1'b0;
            if (disp_req_ok) begin
                disp_pend     <= 1'b1;
                disp_pend_row <= disp_row;
            end
`ifdef BOARD_ROW_CLEAR_EN
            clear_done <= 1'b0;
            if (clr_req_ok) begin
                clr_pend     <= 1'b1;
                clr_pend_row <= clear_row;
            end
`endif

            case (state)
                DFETCH: begin
                    if (step < STEP_W'(BOARD_W)) mem_addr <= fetch_base + ADDR_W'(step);
                    step <= step + STEP_W'(1);
                    if (commit) begin
                        state     <= IDLE;
                        disp_busy <= 1'b0;
                        disp_done <= 1'b1;
                    end
                end
                GACC: begin
                    if (!g_read) begin
                        state <= IDLE;
                    end else if (g_wait) begin
                        g_wait <= 1'b0;
                    end else begin
                        game_rdata  <= g_legal ? mem_rdata : '0;
                        game_rvalid <= 1'b1;
                        state       <= IDLE;
                    end
                end
`ifdef BOARD_ROW_CLEAR_EN
                CLR: begin
                    if (step < STEP_W'(BOARD_W)) begin
                        mem_addr  <= fetch_base + ADDR_W'(step);
                        mem_we    <= 1'b1;
                        mem_wdata <= '0;
                        step      <= step + STEP_W'(1);
                    end else begin
                        clear_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase

            if (arb_slot) begin
                if (disp_want) begin
                    state      <= DFETCH;
                    disp_pend  <= 1'b0;
                    disp_busy  <= 1'b1;
                    fetch_base <= cell_addr(disp_take_row, '0);
                    mem_addr   <= cell_addr(disp_take_row, '0);
                    step       <= STEP_W'(1);
                end
`ifdef BOARD_ROW_CLEAR_EN
                else if (clr_want) begin
                    state      <= CLR;
                    clr_pend   <= 1'b0;
                    fetch_base <= cell_addr(clr_take_row, '0);
                    mem_addr   <= cell_addr(clr_take_row, '0);
                    mem_we     <= 1'b1;
                    mem_wdata  <= '0;
                    step       <= STEP_W'(1);
                end
`endif
                else if (game_req) begin
                    state     <= GACC;
                    game_gnt  <= 1'b1;
                    mem_addr  <= game_legal ? cell_addr(game_row, game_col) : '0;
                    mem_we    <= game_we && game_legal;
                    mem_wdata <= game_wdata;
                    g_read    <= !game_we;
                    g_legal   <= game_legal;
                    g_wait    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_row_arbiter.sv
// Directed bench for board_row_arbiter: row fetch timing, game read/write handshake,
// display priority, pending-row overwrite, illegal coordinates and mid-fetch reset.
module tb_board_row_arbiter;

    logic         Clk = 1'b0;
    logic         reset;
    logic         disp_req;
    logic [4:0]   disp_row;
    logic         disp_busy, disp_done;
    logic [159:0] row_out;
    logic         game_req, game_we;
    logic [4:0]   game_row;
    logic [3:0]   game_col;
    logic [15:0]  game_wdata;
    logic         game_gnt, game_rvalid;
    logic [15:0]  game_rdata;
    logic [7:0]   mem_addr;
    logic         mem_we;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;

    logic [15:0]  ram [0:255];
    logic [159:0] row3_exp;
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 Clk = ~Clk;

    board_row_arbiter dut (
        .Clk         (Clk),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_row    (disp_row),
        .disp_busy   (disp_busy),
        .disp_done   (disp_done),
        .row_out     (row_out),
        .game_req    (game_req),
        .game_we     (game_we),
        .game_row    (game_row),
        .game_col    (game_col),
        .game_wdata  (game_wdata),
        .game_gnt    (game_gnt),
        .game_rvalid (game_rvalid),
        .game_rdata  (game_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Board RAM model: registered read, write-through on mem_we; reset reloads row 3 = 0F00+c.
    always @(posedge Clk) begin
        if (!reset) begin
            for (int a = 0; a < 256; a++)
                ram[a] <= (a >= 30 && a < 40) ? 16'h0F00 + 16'(a - 30) : 16'h0000;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic game_issue(input logic we, input logic [4:0] r, input logic [3:0] c,
                              input logic [15:0] d);
        game_req   = 1'b1;
        game_we    = we;
        game_row   = r;
        game_col   = c;
        game_wdata = d;
        tick();
        game_req   = 1'b0;
    endtask

    initial begin
        logic seen;
        for (int c = 0; c < 10; c++) row3_exp[c*16 +: 16] = 16'h0F00 + 16'(c);
        reset = 1'b0; disp_req = 1'b0; disp_row = '0;
        game_req = 1'b0; game_we = 1'b0; game_row = '0; game_col = '0; game_wdata = '0;
        tick(); tick();

        // Reset state
        check("rst_busy", disp_busy, 0);
        check("rst_done", disp_done, 0);
        check("rst_gnt", game_gnt, 0);
        check("rst_rvalid", game_rvalid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_row_out", row_out, 0);
        reset = 1'b1;
        tick();

        // Fetch row 3: addresses 30..39, disp_done 12 cycles after disp_req
        disp_req = 1'b1; disp_row = 5'd3;
        tick();
        disp_req = 1'b0;
        check("fetch_busy", disp_busy, 1);
        for (int j = 0; j < 12; j++) begin
            if (j > 0) tick();
            if (j < 10) check("fetch_addr", mem_addr, 30 + j);
            check("fetch_done", disp_done, (j == 11));
            if (j == 10) check("no_partial", row_out, 0);
        end
        check("fetch_row", row_out, row3_exp);
        check("fetch_cell9", row_out[9*16 +: 16], 16'h0F09);
        check("fetch_idle", disp_busy, 0);
        tick();
        check("done_pulse", disp_done, 0);

        // Game write (5,2)=00F0 then read back
        game_issue(1'b1, 5'd5, 4'd2, 16'h00F0);
        check("wr_gnt", game_gnt, 1);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 52);
        tick();
        check("wr_gnt_pulse", game_gnt, 0);
        check("wr_we_pulse", mem_we, 0);
        check("wr_ram", ram[52], 16'h00F0);
        game_issue(1'b0, 5'd5, 4'd2, 16'h0000);
        check("rd_gnt", game_gnt, 1);
        check("rd_we", mem_we, 0);
        tick();
        check("rd_wait", game_rvalid, 0);
        tick();
        check("rd_rvalid", game_rvalid, 1);
        check("rd_data", game_rdata, 16'h00F0);
        tick();
        check("rd_rvalid_pulse", game_rvalid, 0);

        // Display and game together: display first, grant with disp_done
        disp_req = 1'b1; disp_row = 5'd3;
        game_req = 1'b1; game_we = 1'b1; game_row = 5'd7; game_col = 4'd1; game_wdata = 16'hABCD;
        tick();
        disp_req = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (j > 0) tick();
            check("both_gnt", game_gnt, (j == 11));
            if (j == 10) check("both_ram_before", ram[71], 16'h0000);
        end
        check("both_done", disp_done, 1);
        check("both_we", mem_we, 1);
        check("both_addr", mem_addr, 71);
        game_req = 1'b0;
        tick();
        check("both_ram_after", ram[71], 16'hABCD);
        check("both_row", row_out, row3_exp);

        // Requests during a fetch: newest row (7) replaces row 5 and is fetched next
        disp_req = 1'b1; disp_row = 5'd3;
        tick();
        for (int j = 1; j <= 11; j++) begin
            disp_req = (j == 3) || (j == 5);
            disp_row = (j == 3) ? 5'd5 : 5'd7;
            tick();
        end
        disp_req = 1'b0;
        check("ovr_done1", disp_done, 1);
        check("ovr_busy1", disp_busy, 1);
        check("ovr_addr", mem_addr, 70);
        repeat (10) tick();
        check("ovr_row_hold", row_out, row3_exp);
        tick();
        check("ovr_done2", disp_done, 1);
        check("ovr_cell1", row_out[1*16 +: 16], 16'hABCD);
        check("ovr_cell0", row_out[0*16 +: 16], 16'h0000);
        check("ovr_no_third", disp_busy, 0);

        // Legal read, then out-of-range read and write
        game_issue(1'b0, 5'd3, 4'd9, 16'h0000);
        check("lrd_addr", mem_addr, 39);
        tick(); tick();
        check("lrd_data", game_rdata, 16'h0F09);
        game_issue(1'b0, 5'd20, 4'd0, 16'h0000);
        check("ird_gnt", game_gnt, 1);
        check("ird_we", mem_we, 0);
        tick(); tick();
        check("ird_rvalid", game_rvalid, 1);
        check("ird_data", game_rdata, 16'h0000);
        game_issue(1'b1, 5'd0, 4'd10, 16'hFFFF);
        check("iwr_gnt", game_gnt, 1);
        check("iwr_we", mem_we, 0);
        tick();
        check("iwr_ram10", ram[10], 16'h0000);
        check("iwr_ram0", ram[0], 16'h0000);

        // disp_row out of range is ignored
        disp_req = 1'b1; disp_row = 5'd20;
        tick();
        disp_req = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 14; j++) begin
            seen = seen | disp_busy | disp_done;
            tick();
        end
        check("bad_row_ignored", seen, 0);

        // Reset while column 5 is being issued
        disp_req = 1'b1; disp_row = 5'd4;
        tick();
        disp_req = 1'b0;
        repeat (5) tick();
        check("mid_addr", mem_addr, 45);
        reset = 1'b0;
        tick();
        check("mid_rst_row", row_out, 0);
        check("mid_rst_busy", disp_busy, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_misc", {disp_done, game_gnt, game_rvalid, mem_we, mem_wdata, game_rdata}, 0);
        reset = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 14; j++) begin
            tick();
            seen = seen | disp_done | disp_busy;
        end
        check("mid_no_done", seen, 0);
        check("mid_row_zero", row_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
